// File: rtl/cam_cfg_i2c.sv
// cam_cfg_i2c: I2C write sequencer that walks a {addr16, data8} register table
// and programs the image sensor over open-drain SCL/SDA. Entries with address
// FFFF end the sequence and FFFE insert a delay of data * DELAY_TICKS_P
// cycles. Busy, done and NACK status let the top level hold the video path off.
module cam_cfg_i2c #(
  parameter logic [6:0] DEV_ADDR_P    = 7'h24,
  parameter int         CLK_DIV_P     = 30,
  parameter int         DELAY_TICKS_P = 12000,
  parameter int         TABLE_DEPTH_P = 256
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic                             start_i,
  output logic [$clog2(TABLE_DEPTH_P)-1:0] cfg_idx_o,
  input  logic [23:0]                      cfg_data_i,
  input  logic                             scl_i,
  input  logic                             sda_i,
  output logic                             scl_oe_o,
  output logic                             sda_oe_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             error_o,
  output logic [$clog2(TABLE_DEPTH_P)-1:0] err_idx_o
);

  localparam int IDX_W = $clog2(TABLE_DEPTH_P);
  localparam int QW    = $clog2(CLK_DIV_P);
  localparam int DW    = $clog2(255 * DELAY_TICKS_P + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_BYTE, S_STOP, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] err_idx;
  logic [QW-1:0]    qcnt;
  logic [1:0]       phase;
  logic [3:0]       bit_cnt;
  logic [1:0]       byte_sel;
  logic             fetch_wait;
  logic             nack_pend;
  logic             armed;
  logic [23:0]      entry;
  logic [DW-1:0]    dly;
  logic [7:0]       cur_byte;

  logic idle_like, scl_rel, stall, qend, tick, ack_end, last, start_ok, entering;

  assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  // Phases in which SCL is released; a slave may stretch the clock there.
  assign scl_rel   = ((state == S_START) && (phase != 2'd2)) ||
                     ((state == S_BYTE)  && phase[1]) ||
                     ((state == S_STOP)  && (phase != 2'd0));
  assign stall     = scl_rel && !scl_i;
  assign qend      = (qcnt == QW'(CLK_DIV_P - 1));
  assign tick      = qend && !stall;
  assign ack_end   = (state == S_BYTE) && tick && (phase == 2'd3) && (bit_cnt == 4'd8);
  assign last      = (idx == IDX_W'(TABLE_DEPTH_P - 1));
  // The first edge after reset release only arms the block, so a start pulse
  // coincident with deassertion is dropped.
  assign start_ok  = start_i && armed;
  assign entering  = (state_nx != state);

  // Select the byte on the wire: device address, register hi, register lo, data
  always_comb begin
    cur_byte = {DEV_ADDR_P, 1'b0};
    case (byte_sel)
      2'd1:    cur_byte = entry[23:16];
      2'd2:    cur_byte = entry[15:8];
      2'd3:    cur_byte = entry[7:0];
      default: cur_byte = {DEV_ADDR_P, 1'b0};
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start_ok) state_nx = S_FETCH;
      S_FETCH: begin
        if (fetch_wait) begin
          if (cfg_data_i[23:8] == 16'hFFFF)      state_nx = S_DONE;
          else if (cfg_data_i[23:8] == 16'hFFFE) state_nx = S_DELAY;
          else                                   state_nx = S_START;
        end
      end
      S_START: if (tick && (phase == 2'd2)) state_nx = S_BYTE;
      S_BYTE:  if (ack_end && (sda_i || (byte_sel == 2'd3))) state_nx = S_STOP;
      S_STOP: begin
        if (tick && (phase == 2'd2)) begin
          if (nack_pend) state_nx = S_ERROR;
          else if (last) state_nx = S_DONE;
          else           state_nx = S_FETCH;
        end
      end
      S_DELAY: if (dly == '0) state_nx = last ? S_DONE : S_FETCH;
      default: state_nx = S_IDLE;
    endcase
  end

  // Bus drive and status outputs decoded from state and bit position
  always_comb begin
    scl_oe_o  = 1'b0;
    sda_oe_o  = 1'b0;
    busy_o    = !idle_like;
    done_o    = (state == S_DONE);
    error_o   = (state == S_ERROR);
    cfg_idx_o = idx;
    err_idx_o = err_idx;
    case (state)
      S_START: begin
        sda_oe_o = (phase != 2'd0);
        scl_oe_o = (phase == 2'd2);
      end
      S_BYTE: begin
        scl_oe_o = !phase[1];
        sda_oe_o = (bit_cnt == 4'd8) ? 1'b0 : !cur_byte[~bit_cnt[2:0]];
      end
      S_STOP: begin
        scl_oe_o = (phase == 2'd0);
        sda_oe_o = (phase != 2'd2);
      end
      default: begin
        scl_oe_o = 1'b0;
        sda_oe_o = 1'b0;
      end
    endcase
  end

  // Control registers: quarter divider, bit/byte position, table index, status
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      armed      <= 1'b0;
      fetch_wait <= 1'b0;
      qcnt       <= '0;
      phase      <= '0;
      bit_cnt    <= '0;
      byte_sel   <= '0;
      idx        <= '0;
      err_idx    <= '0;
      nack_pend  <= 1'b0;
    end else begin
      armed      <= 1'b1;
      fetch_wait <= (state == S_FETCH) && !fetch_wait;
      if (idle_like || entering) qcnt <= '0;
      else if (!stall)           qcnt <= qend ? '0 : qcnt + 1'b1;
      if (entering)  phase <= '0;
      else if (tick) phase <= phase + 2'd1;
      if (state == S_START) begin
        bit_cnt  <= '0;
        byte_sel <= '0;
      end else if ((state == S_BYTE) && tick && (phase == 2'd3)) begin
        if (bit_cnt == 4'd8) begin
          bit_cnt  <= '0;
          byte_sel <= byte_sel + 2'd1;
        end else begin
          bit_cnt  <= bit_cnt + 4'd1;
        end
      end
      if (idle_like && start_ok) begin
        idx       <= '0;
        err_idx   <= '0;
        nack_pend <= 1'b0;
      end else begin
        if (ack_end && sda_i) begin
          nack_pend <= 1'b1;
          err_idx   <= idx;
        end
        if ((state_nx == S_FETCH) && ((state == S_STOP) || (state == S_DELAY)))
          idx <= idx + 1'b1;
      end
    end
  end

  // Table entry latch and delay countdown (data path, no reset needed)
  always_ff @(posedge clk_i) begin
    if ((state == S_FETCH) && fetch_wait) begin
      entry <= cfg_data_i;
      dly   <= DW'(cfg_data_i[7:0]) * DW'(DELAY_TICKS_P);
    end else if ((state == S_DELAY) && (dly != '0)) begin
      dly   <= dly - 1'b1;
    end
  end

endmodule

// File: tb/tb_cam_cfg_i2c.sv
// Bench for cam_cfg_i2c: registered table ROM, open-drain bus with an I2C
// slave that ACKs/NACKs selected bytes and can stretch SCL, and a table of
// directed runs plus hand-written restart/stretch/reset sequences.
module tb_cam_cfg_i2c;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  cfg_idx;
  logic [23:0] cfg_data;
  logic        scl_oe, sda_oe, busy, done, error;
  logic [1:0]  err_idx;
  logic        hold = 1'b0;
  logic        slave_sda = 1'b0;
  logic        scl, sda;
  logic [23:0] rom [DEPTH];

  assign scl = ~(scl_oe | hold);
  assign sda = ~(sda_oe | slave_sda);

  cam_cfg_i2c #(
    .DEV_ADDR_P(7'h24), .CLK_DIV_P(4), .DELAY_TICKS_P(10), .TABLE_DEPTH_P(DEPTH)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .cfg_idx_o(cfg_idx),
    .cfg_data_i(cfg_data), .scl_i(scl), .sda_i(sda), .scl_oe_o(scl_oe),
    .sda_oe_o(sda_oe), .busy_o(busy), .done_o(done), .error_o(error),
    .err_idx_o(err_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cfg_data <= rom[cfg_idx];

  int nchk = 0, nerr = 0;
  int ncyc = 0, frames = 0, act = 0;
  logic [7:0] got[$];
  bit   in_frame = 0, hi_ok = 0, pscl = 1, psda = 1, stretch_arm = 0;
  int   bitc = 0, bidx = 0, hi_start = 0, hi_min = 1000, hi_max = 0;
  int   nack_frame = -1, nack_byte = -1, hcnt = 0, ack_fall = 0, ack_period = 0;
  logic [7:0] sh = 8'h00;

  // Slave/monitor: decodes START/STOP/bits, answers ACK/NACK, stretches SCL
  always @(negedge clk) begin
    bit cs, ds;
    int w;
    ncyc++;
    cs = !(scl_oe || hold);
    ds = !(sda_oe || slave_sda);
    if (scl_oe || sda_oe) act++;
    if (!rstn) begin
      in_frame = 0; bitc = 0; bidx = 0; slave_sda = 0; hold = 0; hcnt = 0; hi_ok = 0;
    end else begin
      if (hcnt > 0) begin
        hcnt--;
        if (hcnt == 0) hold = 0;
      end
      if (pscl && cs && psda && !ds) begin
        in_frame = 1; bitc = 0; bidx = 0; hi_ok = 0;
      end else if (pscl && cs && !psda && ds) begin
        if (in_frame) frames++;
        in_frame = 0; hi_ok = 0;
      end else if (in_frame && !pscl && cs) begin
        if (bitc < 8) sh = {sh[6:0], ds};
        bitc++; hi_start = ncyc; hi_ok = 1;
      end else if (in_frame && pscl && !cs) begin
        if (hi_ok) begin
          w = ncyc - hi_start;
          if (w < hi_min) hi_min = w;
          if (w > hi_max) hi_max = w;
          hi_ok = 0;
        end
        if (bitc == 8) begin
          got.push_back(sh);
          slave_sda = !((frames == nack_frame) && (bidx == nack_byte));
          ack_fall = ncyc;
          if (stretch_arm && bidx == 0) begin
            stretch_arm = 0; hold = 1; hcnt = 58;
          end
        end else if (bitc == 9) begin
          slave_sda = 0;
          if (frames == 0 && bidx == 0) ack_period = ncyc - ack_fall;
          bitc = 0; bidx++;
        end
      end
    end
    pscl = cs; psda = ds;
  end

  task automatic chk(input string name, input int actual, input int expected);
    nchk++;
    if (actual !== expected) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual,
               expected, expected);
    end
  endtask

  task automatic load(input logic [95:0] tab);
    for (int i = 0; i < DEPTH; i++) rom[i] = tab[95-24*i -: 24];
  endtask

  task automatic clear_log();
    got.delete(); frames = 0; hi_min = 1000; hi_max = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output int lat);
    lat = 1;
    while (busy && lat < maxc) begin
      @(negedge clk);
      lat++;
    end
    chk("run_timeout_busy", int'(busy), 0);
  endtask

  task automatic chk_bytes(input string name, input int n, input logic [127:0] exp);
    int gb;
    chk({name, "_nbytes"}, got.size(), n);
    for (int k = 0; k < n; k++) begin
      gb = (k < got.size()) ? int'(got[k]) : -1;
      chk($sformatf("%s_byte%0d", name, k), gb, int'(exp[127-8*k -: 8]));
    end
  endtask

  typedef struct {
    logic [95:0]  tab;
    int           nack_f, nack_b;
    int           nbytes;
    logic [127:0] bytes;
    int           nframes;
    logic         exp_done, exp_err;
    int           exp_eidx;
    int           lat_min, lat_max;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;
    // basic two writes then end marker
    vecs[0] = '{96'h010301_010001_FFFF00_000000, -1, -1, 8,
                128'h48010301_48010001_00000000_00000000, 2, 1'b1, 1'b0, 0, 1, 3000};
    // NACK on register-lo byte of entry 1
    vecs[1] = '{96'h010301_010001_FFFF00_000000, 1, 2, 7,
                128'h48010301_48010000_00000000_00000000, 2, 1'b0, 1'b1, 1, 1, 3000};
    // delay of 3 units, no bus activity
    vecs[2] = '{96'hFFFE03_FFFF00_000000_000000, -1, -1, 0,
                128'h0, 0, 1'b1, 1'b0, 0, 30, 40};
    // no end marker: last entry executes, then done
    vecs[3] = '{96'hAB125A_0000FF_123400_8001C3, -1, -1, 16,
                128'h48AB125A_480000FF_48123400_488001C3, 4, 1'b1, 1'b0, 0, 1, 3000};
    // zero-length delay is skipped
    vecs[4] = '{96'hFFFE00_004299_FFFF00_000000, -1, -1, 4,
                128'h48004299_00000000_00000000_00000000, 1, 1'b1, 1'b0, 0, 1, 3000};
    // NACK on device address of entry 0
    vecs[5] = '{96'h300011_FFFF00_000000_000000, 0, 0, 1,
                128'h48000000_00000000_00000000_00000000, 1, 1'b0, 1'b1, 0, 1, 3000};
    // NACK on data byte of entry 2
    vecs[6] = '{96'h000101_000202_000303_FFFF00, 2, 3, 12,
                128'h48000101_48000202_48000303_00000000, 3, 1'b0, 1'b1, 2, 1, 3000};

    load(vecs[0].tab);
    rstn = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_scl_oe", int'(scl_oe), 0);
    chk("rst_sda_oe", int'(sda_oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_err_idx", int'(err_idx), 0);
    chk("rst_cfg_idx", int'(cfg_idx), 0);
    // start held high across reset release must be ignored
    rstn = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start_at_release_ignored", int'(busy), 0);
    repeat (3) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      load(vecs[v].tab);
      nack_frame = vecs[v].nack_f;
      nack_byte  = vecs[v].nack_b;
      clear_log();
      pulse_start();
      wait_idle(5000, lat);
      chk($sformatf("v%0d_latency_in_window", v),
          int'(lat >= vecs[v].lat_min && lat <= vecs[v].lat_max), 1);
      chk($sformatf("v%0d_done", v), int'(done), int'(vecs[v].exp_done));
      chk($sformatf("v%0d_error", v), int'(error), int'(vecs[v].exp_err));
      chk($sformatf("v%0d_err_idx", v), int'(err_idx), vecs[v].exp_eidx);
      chk_bytes($sformatf("v%0d", v), vecs[v].nbytes, vecs[v].bytes);
      chk($sformatf("v%0d_frames", v), frames, vecs[v].nframes);
      if (vecs[v].nframes > 0) begin
        chk($sformatf("v%0d_scl_high_min", v), hi_min, 8);
        chk($sformatf("v%0d_scl_high_max", v), hi_max, 8);
      end
      act = 0;
      repeat (100) @(negedge clk);
      chk($sformatf("v%0d_idle_bus_activity", v), act, 0);
      chk($sformatf("v%0d_done_sticky", v), int'(done), int'(vecs[v].exp_done));
    end
    nack_frame = -1;
    nack_byte  = -1;

    // clock stretching on ACK of byte 0
    load(vecs[0].tab);
    clear_log();
    ack_period = 0;
    stretch_arm = 1;
    pulse_start();
    wait_idle(5000, lat);
    chk("stretch_ack_period", ack_period, 66);
    chk_bytes("stretch", 8, vecs[0].bytes);
    chk("stretch_done", int'(done), 1);

    // start while busy is ignored; start after done reruns from index 0
    clear_log();
    pulse_start();
    repeat (60) @(negedge clk);
    chk("restart_busy_mid", int'(busy), 1);
    pulse_start();
    wait_idle(5000, lat);
    chk("restart_frames_first", frames, 2);
    chk_bytes("restart_first", 8, vecs[0].bytes);
    chk("restart_done_first", int'(done), 1);
    clear_log();
    pulse_start();
    chk("restart_done_cleared", int'(done), 0);
    chk("restart_busy_again", int'(busy), 1);
    chk("restart_idx_zero", int'(cfg_idx), 0);
    wait_idle(5000, lat);
    chk_bytes("restart_second", 8, vecs[0].bytes);
    chk("restart_done_second", int'(done), 1);

    // reset asserted during bit 4 of byte 2 (SCL and SDA both driven low)
    clear_log();
    pulse_start();
    lat = 0;
    while (!(bidx == 2 && bitc == 4 && scl_oe) && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    chk("midbyte_reached", int'(lat < 3000), 1);
    chk("midbyte_sda_driven", int'(sda_oe), 1);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_scl_oe", int'(scl_oe), 0);
    chk("midrst_sda_oe", int'(sda_oe), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_error", int'(error), 0);
    chk("midrst_cfg_idx", int'(cfg_idx), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    act = 0;
    repeat (100) @(negedge clk);
    chk("midrst_idle_activity", act, 0);
    chk("midrst_idle_busy", int'(busy), 0);
    clear_log();
    pulse_start();
    wait_idle(5000, lat);
    chk_bytes("after_rst", 8, vecs[0].bytes);
    chk("after_rst_done", int'(done), 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", nchk, nerr);
    $fatal(1);
  end

endmodule
